// File: rtl/fu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fu_arbiter
// Purpose  : Two-requester round-robin arbiter in front of a single function
//            unit. Accepts one operation at a time, holds its operands in
//            registers while the unit works, waits FU_LAT cycles, captures the
//            result for the granted requester and holds it until acknowledged.
// Ports    : CLK/RESET             clock, synchronous active-high reset
//            reqN_valid/ready      request handshake per requester
//            reqN_A/B/SH/FS        operands, shift amount, function select
//            respN_valid/F/flags   captured result {Z,C,N,V} per requester
//            respN_ack             response consumed
//            fu_A/B/SH/FS          registered operands to the function unit
//            fu_F, fu_Z/C/N/V      function-unit result and flags
//            busy                  an operation is in flight
// Revision : 1.0 - initial release
// ============================================================================
module fu_arbiter #(
    parameter int FU_LAT = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        req0_valid,
    input  logic        req1_valid,
    input  logic [31:0] req0_A,
    input  logic [31:0] req0_B,
    input  logic [31:0] req1_A,
    input  logic [31:0] req1_B,
    input  logic [4:0]  req0_SH,
    input  logic [4:0]  req1_SH,
    input  logic [4:0]  req0_FS,
    input  logic [4:0]  req1_FS,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        resp0_valid,
    output logic        resp1_valid,
    output logic [31:0] resp0_F,
    output logic [31:0] resp1_F,
    output logic [3:0]  resp0_flags,
    output logic [3:0]  resp1_flags,
    input  logic        resp0_ack,
    input  logic        resp1_ack,
    output logic [31:0] fu_A,
    output logic [31:0] fu_B,
    output logic [4:0]  fu_SH,
    output logic [4:0]  fu_FS,
    input  logic [31:0] fu_F,
    input  logic        fu_Z,
    input  logic        fu_C,
    input  logic        fu_N,
    input  logic        fu_V,
    output logic        busy
);

    // Counter is loaded with FU_LAT-1 so that capture lands FU_LAT edges
    // after the accept edge.
    localparam logic [1:0] c_CNT_INIT = 2'(FU_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_last_grant;
    logic        r_grant;
    logic [1:0]  r_cnt;
    logic [31:0] r_op_A;
    logic [31:0] r_op_B;
    logic [4:0]  r_op_SH;
    logic [4:0]  r_op_FS;
    logic        r_resp0_valid;
    logic        r_resp1_valid;
    logic [31:0] r_resp0_F;
    logic [31:0] r_resp1_F;
    logic [3:0]  r_resp0_flags;
    logic [3:0]  r_resp1_flags;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_ack;
    logic [3:0]  w_fu_flags;

    // Ready is suppressed during reset so nothing appears accepted at an
    // edge that reset overrides anyway.
    assign w_idle     = (r_state == S_IDLE) && !RESET;
    // On a tie the requester that did not win last time is granted.
    assign w_grant0   = w_idle && req0_valid && (!req1_valid || r_last_grant);
    assign w_grant1   = w_idle && req1_valid && (!req0_valid || !r_last_grant);
    // Only the granted requester's ack can close the response phase.
    assign w_ack      = r_grant ? resp1_ack : resp0_ack;
    assign w_fu_flags = {fu_Z, fu_C, fu_N, fu_V};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_last_grant  <= 1'b1;
            r_grant       <= 1'b0;
            r_cnt         <= 2'd0;
            r_op_A        <= 32'd0;
            r_op_B        <= 32'd0;
            r_op_SH       <= 5'd0;
            r_op_FS       <= 5'd0;
            r_resp0_valid <= 1'b0;
            r_resp1_valid <= 1'b0;
            r_resp0_F     <= 32'd0;
            r_resp1_F     <= 32'd0;
            r_resp0_flags <= 4'd0;
            r_resp1_flags <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_op_A       <= w_grant1 ? req1_A  : req0_A;
                        r_op_B       <= w_grant1 ? req1_B  : req0_B;
                        r_op_SH      <= w_grant1 ? req1_SH : req0_SH;
                        r_op_FS      <= w_grant1 ? req1_FS : req0_FS;
                        r_grant      <= w_grant1;
                        r_last_grant <= w_grant1;
                        r_cnt        <= c_CNT_INIT;
                        r_state      <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    if (r_cnt == 2'd0) begin
                        if (r_grant) begin
                            r_resp1_F     <= fu_F;
                            r_resp1_flags <= w_fu_flags;
                            r_resp1_valid <= 1'b1;
                        end else begin
                            r_resp0_F     <= fu_F;
                            r_resp0_flags <= w_fu_flags;
                            r_resp0_valid <= 1'b1;
                        end
                        r_state <= S_RESP;
                    end else begin
                        r_cnt <= r_cnt - 2'd1;
                    end
                end
                S_RESP: begin
                    if (w_ack) begin
                        r_resp0_valid <= 1'b0;
                        r_resp1_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req0_ready  = w_grant0;
    assign req1_ready  = w_grant1;
    assign resp0_valid = r_resp0_valid;
    assign resp1_valid = r_resp1_valid;
    assign resp0_F     = r_resp0_F;
    assign resp1_F     = r_resp1_F;
    assign resp0_flags = r_resp0_flags;
    assign resp1_flags = r_resp1_flags;
    assign fu_A        = r_op_A;
    assign fu_B        = r_op_B;
    assign fu_SH       = r_op_SH;
    assign fu_FS       = r_op_FS;
    assign busy        = (r_state != S_IDLE) && !RESET;

endmodule
`default_nettype wire

// File: tb/tb_fu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_arbiter
// Purpose  : Self-checking bench for fu_arbiter. Two instances are built,
//            FU_LAT=1 (index 0) and FU_LAT=3 (index 1), each with its own
//            behavioural function-unit model. A transaction-level reference
//            model tracks grants, latency and held responses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fu_arbiter;

    localparam int c_LAT0 = 1;
    localparam int c_LAT1 = 3;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    // Stimulus, indexed [dut][requester]
    logic [1:0]  rv   [2];
    logic [1:0]  ack  [2];
    logic [31:0] rA   [2][2];
    logic [31:0] rB   [2][2];
    logic [4:0]  rSH  [2][2];
    logic [4:0]  rFS  [2][2];

    // Observed outputs
    logic [1:0]  rdy  [2];
    logic [1:0]  rsv  [2];
    logic [31:0] rF   [2][2];
    logic [3:0]  rfl  [2][2];
    logic [31:0] fuA  [2];
    logic [31:0] fuB  [2];
    logic [4:0]  fuSH [2];
    logic [4:0]  fuFS [2];
    logic        bsy  [2];

    int n_total = 0;
    int n_bad   = 0;

    // Function unit: FS[1:0] selects xor, shift-left, add, subtract.
    // Result packs {Z,C,N,V,F}.
    function automatic logic [35:0] fu_calc(input logic [31:0] a, input logic [31:0] b,
                                            input logic [4:0] sh, input logic [4:0] fs);
        logic [32:0] s;
        logic [31:0] r;
        logic        c;
        logic        v;
        c = 1'b0;
        v = 1'b0;
        s = 33'd0;
        case (fs[1:0])
            2'd0: r = a ^ b;
            2'd1: r = a << sh;
            2'd2: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            default: begin
                r = a - b;
                c = (a >= b);
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
        endcase
        return {(r == 32'd0), c, r[31], v, r};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        logic        w_rdy0, w_rdy1, w_v0, w_v1, w_busy;
        logic [31:0] w_F0, w_F1, w_fa, w_fb, w_ff;
        logic [3:0]  w_fl0, w_fl1, w_fflags;
        logic [4:0]  w_fsh, w_ffs;

        assign {w_fflags, w_ff} = fu_calc(w_fa, w_fb, w_fsh, w_ffs);

        fu_arbiter #(.FU_LAT(g == 0 ? c_LAT0 : c_LAT1)) u_dut (
            .CLK         (CLK),
            .RESET       (RESET),
            .req0_valid  (rv[g][0]),
            .req1_valid  (rv[g][1]),
            .req0_A      (rA[g][0]),
            .req0_B      (rB[g][0]),
            .req1_A      (rA[g][1]),
            .req1_B      (rB[g][1]),
            .req0_SH     (rSH[g][0]),
            .req1_SH     (rSH[g][1]),
            .req0_FS     (rFS[g][0]),
            .req1_FS     (rFS[g][1]),
            .req0_ready  (w_rdy0),
            .req1_ready  (w_rdy1),
            .resp0_valid (w_v0),
            .resp1_valid (w_v1),
            .resp0_F     (w_F0),
            .resp1_F     (w_F1),
            .resp0_flags (w_fl0),
            .resp1_flags (w_fl1),
            .resp0_ack   (ack[g][0]),
            .resp1_ack   (ack[g][1]),
            .fu_A        (w_fa),
            .fu_B        (w_fb),
            .fu_SH       (w_fsh),
            .fu_FS       (w_ffs),
            .fu_F        (w_ff),
            .fu_Z        (w_fflags[3]),
            .fu_C        (w_fflags[2]),
            .fu_N        (w_fflags[1]),
            .fu_V        (w_fflags[0]),
            .busy        (w_busy)
        );

        assign rdy[g]    = {w_rdy1, w_rdy0};
        assign rsv[g]    = {w_v1, w_v0};
        assign rF[g][0]  = w_F0;
        assign rF[g][1]  = w_F1;
        assign rfl[g][0] = w_fl0;
        assign rfl[g][1] = w_fl1;
        assign fuA[g]    = w_fa;
        assign fuB[g]    = w_fb;
        assign fuSH[g]   = w_fsh;
        assign fuFS[g]   = w_ffs;
        assign bsy[g]    = w_busy;
    end

    // ------------------------------------------------------------------
    // Reference model (transaction level)
    // m_left counts edges remaining until the result is captured;
    // zero with m_inf set means the result is waiting for its ack.
    // ------------------------------------------------------------------
    bit          m_inf  [2];
    int          m_left [2];
    int          m_gr   [2];
    int          m_last [2];
    logic [1:0]  m_rv   [2];
    logic [31:0] m_F    [2][2];
    logic [3:0]  m_fl   [2][2];
    logic [31:0] m_A    [2];
    logic [31:0] m_B    [2];
    logic [4:0]  m_SH   [2];
    logic [4:0]  m_FS   [2];

    function automatic bit exp_ready(int d, int i);
        int o;
        o = 1 - i;
        if (RESET || m_inf[d]) return 1'b0;
        return rv[d][i] && (!rv[d][o] || m_last[d] == o);
    endfunction

    task automatic model_step(int d);
        bit r0, r1;
        int i;
        logic [35:0] res;
        r0 = exp_ready(d, 0);
        r1 = exp_ready(d, 1);
        if (RESET) begin
            m_inf[d] = 1'b0; m_left[d] = 0; m_gr[d] = 0; m_last[d] = 1;
            m_rv[d] = 2'b00;
            m_F[d][0] = 32'd0; m_F[d][1] = 32'd0;
            m_fl[d][0] = 4'd0; m_fl[d][1] = 4'd0;
            m_A[d] = 32'd0; m_B[d] = 32'd0; m_SH[d] = 5'd0; m_FS[d] = 5'd0;
        end else if (!m_inf[d]) begin
            if (r0 || r1) begin
                i = r0 ? 0 : 1;
                m_A[d] = rA[d][i]; m_B[d] = rB[d][i];
                m_SH[d] = rSH[d][i]; m_FS[d] = rFS[d][i];
                m_gr[d] = i; m_last[d] = i;
                m_left[d] = (d == 0) ? c_LAT0 : c_LAT1;
                m_inf[d] = 1'b1;
            end
        end else if (m_left[d] > 0) begin
            m_left[d] = m_left[d] - 1;
            if (m_left[d] == 0) begin
                res = fu_calc(m_A[d], m_B[d], m_SH[d], m_FS[d]);
                m_F[d][m_gr[d]]  = res[31:0];
                m_fl[d][m_gr[d]] = res[35:32];
                m_rv[d][m_gr[d]] = 1'b1;
            end
        end else if (ack[d][m_gr[d]]) begin
            m_rv[d] = 2'b00;
            m_inf[d] = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic idle_inputs(int d);
        rv[d] = 2'b00;
        ack[d] = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rA[d][i] = 32'd0; rB[d][i] = 32'd0; rSH[d][i] = 5'd0; rFS[d][i] = 5'd0;
        end
    endtask

    task automatic rand_ops(int d, int i);
        rA[d][i]  = $urandom;
        rB[d][i]  = $urandom;
        rSH[d][i] = 5'($urandom_range(0, 31));
        rFS[d][i] = 5'($urandom_range(0, 31));
    endtask

    task automatic wait_resp(int d, int i, int maxc, output bit ok);
        ok = 1'b0;
        for (int k = 0; k < maxc; k++) begin
            if (rsv[d][i]) ok = 1'b1;
            if (!ok) tick();
        end
        if (rsv[d][i]) ok = 1'b1;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RESET = 1'b1;
        rv[0] = 2'b11; rv[1] = 2'b11;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdy[d] !== 2'b00 || bsy[d] !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_rdy_busy dut%0d: got rdy=%b busy=%b want rdy=00 busy=0", d, rdy[d], bsy[d]);
            end
        end
        tick();
        tick();
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if ({rsv[d], rF[d][0], rF[d][1], rfl[d][0], rfl[d][1], fuA[d], fuB[d], fuSH[d], fuFS[d]} !== '0) begin
                n_bad++;
                $display("FAIL reset_outputs dut%0d: got rsv=%b F0=%h F1=%h fuA=%h fuB=%h want all 0",
                         d, rsv[d], rF[d][0], rF[d][1], fuA[d], fuB[d]);
            end
        end
        RESET = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            n_total++;
            if (rdy[d] !== 2'b01) begin
                n_bad++;
                $display("FAIL reset_first_tie dut%0d: got rdy=%b want 01", d, rdy[d]);
            end
        end
        idle_inputs(0);
        idle_inputs(1);
    endtask

    task automatic test_single();
        rA[0][0] = 32'd5; rB[0][0] = 32'd7; rSH[0][0] = 5'd0; rFS[0][0] = 5'b00010;
        rv[0] = 2'b01;
        #1;
        n_total++;
        if (rdy[0] !== 2'b01) begin n_bad++; $display("FAIL single_ready: got %b want 01", rdy[0]); end
        tick();                                   // accept edge t
        rv[0] = 2'b00;
        n_total++;
        if (bsy[0] !== 1'b1 || rsv[0] !== 2'b00) begin
            n_bad++; $display("FAIL single_exec: got busy=%b rsv=%b want busy=1 rsv=00", bsy[0], rsv[0]);
        end
        tick();                                   // t+1: capture
        n_total++;
        if (rsv[0] !== 2'b01 || rF[0][0] !== 32'd12 || rfl[0][0] !== 4'b0000) begin
            n_bad++; $display("FAIL single_resp: got rsv=%b F=%0d fl=%b want rsv=01 F=12 fl=0000", rsv[0], rF[0][0], rfl[0][0]);
        end
        tick();                                   // t+2: held
        n_total++;
        if (rsv[0] !== 2'b01 || rF[0][0] !== 32'd12) begin
            n_bad++; $display("FAIL single_hold: got rsv=%b F=%0d want rsv=01 F=12", rsv[0], rF[0][0]);
        end
        ack[0] = 2'b01;
        tick();                                   // t+3: ack sampled
        ack[0] = 2'b00;
        n_total++;
        if (rsv[0] !== 2'b00 || bsy[0] !== 1'b0 || rF[0][0] !== 32'd12) begin
            n_bad++; $display("FAIL single_ack: got rsv=%b busy=%b F=%0d want rsv=00 busy=0 F=12", rsv[0], bsy[0], rF[0][0]);
        end
        rA[0][0] = 32'd1; rB[0][0] = 32'd2;
        rv[0] = 2'b01;
        #1;
        n_total++;
        if (rdy[0] !== 2'b01) begin n_bad++; $display("FAIL single_ready_again: got %b want 01", rdy[0]); end
        tick();                                   // t+4: accept
        rv[0] = 2'b00;
        tick();
        n_total++;
        if (rsv[0] !== 2'b01 || rF[0][0] !== 32'd3) begin
            n_bad++; $display("FAIL single_second: got rsv=%b F=%0d want rsv=01 F=3", rsv[0], rF[0][0]);
        end
        ack[0] = 2'b01;
        tick();
        ack[0] = 2'b00;
    endtask

    task automatic test_tie(int d);
        bit ok;
        int e;
        logic [35:0] res;
        do_reset();
        rand_ops(d, 0);
        rand_ops(d, 1);
        rv[d] = 2'b11;
        for (int k = 0; k < 4; k++) begin
            e = k % 2;
            #1;
            n_total++;
            if (rdy[d] !== ((e == 1) ? 2'b10 : 2'b01)) begin
                n_bad++; $display("FAIL tie_order dut%0d step%0d: got rdy=%b want grant to req%0d", d, k, rdy[d], e);
            end
            res = fu_calc(rA[d][e], rB[d][e], rSH[d][e], rFS[d][e]);
            tick();
            rand_ops(d, 0);
            rand_ops(d, 1);
            wait_resp(d, e, 6, ok);
            n_total++;
            if (!ok || rF[d][e] !== res[31:0] || rfl[d][e] !== res[35:32]) begin
                n_bad++; $display("FAIL tie_result dut%0d step%0d: got valid=%b F=%h fl=%b want F=%h fl=%b",
                                  d, k, ok, rF[d][e], rfl[d][e], res[31:0], res[35:32]);
            end
            ack[d][e] = 1'b1;
            tick();
            ack[d] = 2'b00;
        end
        idle_inputs(d);
    endtask

    task automatic test_latency();
        logic [31:0] la, lb;
        logic [4:0]  lsh, lfs;
        logic [35:0] res;
        rand_ops(1, 0);
        la = rA[1][0]; lb = rB[1][0]; lsh = rSH[1][0]; lfs = rFS[1][0];
        res = fu_calc(la, lb, lsh, lfs);
        rv[1] = 2'b01;
        tick();                                   // accept edge t
        for (int c = 1; c <= 3; c++) begin
            rv[1] = 2'($urandom_range(0, 3));
            rand_ops(1, 0);
            rand_ops(1, 1);
            #1;
            n_total++;
            if (fuA[1] !== la || fuB[1] !== lb || fuSH[1] !== lsh || fuFS[1] !== lfs) begin
                n_bad++; $display("FAIL lat_fu_stable c%0d: got A=%h B=%h want A=%h B=%h", c, fuA[1], fuB[1], la, lb);
            end
            tick();
            n_total++;
            if (c < 3 && rsv[1] !== 2'b00) begin
                n_bad++; $display("FAIL lat_early c%0d: got rsv=%b want 00", c, rsv[1]);
            end else if (c == 3 && (rsv[1] !== 2'b01 || rF[1][0] !== res[31:0] || rfl[1][0] !== res[35:32])) begin
                n_bad++; $display("FAIL lat_capture: got rsv=%b F=%h fl=%b want rsv=01 F=%h fl=%b",
                                  rsv[1], rF[1][0], rfl[1][0], res[31:0], res[35:32]);
            end
        end
        rv[1] = 2'b00;
        ack[1] = 2'b01;
        tick();
        idle_inputs(1);
    endtask

    task automatic test_backpressure();
        logic [31:0] f0;
        logic [3:0]  fl0;
        rand_ops(0, 0);
        rand_ops(0, 1);
        rv[0] = 2'b01;
        tick();                                   // accept req0
        rv[0] = 2'b11;
        tick();                                   // capture
        f0 = rF[0][0];
        fl0 = rfl[0][0];
        for (int k = 0; k < 10; k++) begin
            n_total++;
            if (rsv[0] !== 2'b01 || rF[0][0] !== f0 || rfl[0][0] !== fl0 || rdy[0] !== 2'b00 || bsy[0] !== 1'b1) begin
                n_bad++; $display("FAIL backpressure k%0d: got rsv=%b F=%h rdy=%b busy=%b want rsv=01 F=%h rdy=00 busy=1",
                                  k, rsv[0], rF[0][0], rdy[0], bsy[0], f0);
            end
            tick();
        end
        ack[0] = 2'b01;
        tick();
        ack[0] = 2'b00;
        rv[0] = 2'b10;
        #1;
        n_total++;
        if (rdy[0] !== 2'b10) begin n_bad++; $display("FAIL backpressure_release: got rdy=%b want 10", rdy[0]); end
        tick();
        rv[0] = 2'b00;
        tick();
        ack[0] = 2'b10;
        tick();
        idle_inputs(0);
    endtask

    task automatic test_reset_exec();
        rand_ops(1, 0);
        rv[1] = 2'b01;
        tick();                                   // accept edge t
        rv[1] = 2'b00;
        RESET = 1'b1;
        tick();                                   // t+1 reset
        RESET = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_total++;
            if (rsv[1] !== 2'b00) begin n_bad++; $display("FAIL rst_exec_noresp k%0d: got rsv=%b want 00", k, rsv[1]); end
        end
        n_total++;
        if ({rF[1][0], rF[1][1], rfl[1][0], rfl[1][1], fuA[1], fuB[1], fuSH[1], fuFS[1], bsy[1]} !== '0) begin
            n_bad++; $display("FAIL rst_exec_zero: got F0=%h fuA=%h fuB=%h busy=%b want all 0", rF[1][0], fuA[1], fuB[1], bsy[1]);
        end
        rv[1] = 2'b11;
        #1;
        n_total++;
        if (rdy[1] !== 2'b01) begin n_bad++; $display("FAIL rst_exec_tie: got rdy=%b want 01", rdy[1]); end
        idle_inputs(1);
    endtask

    task automatic test_stray_ack();
        ack[1] = 2'b10;
        for (int k = 0; k < 2; k++) begin
            tick();
            n_total++;
            if (bsy[1] !== 1'b0 || rsv[1] !== 2'b00) begin
                n_bad++; $display("FAIL stray_idle k%0d: got busy=%b rsv=%b want 0 00", k, bsy[1], rsv[1]);
            end
        end
        ack[1] = 2'b00;
        rand_ops(1, 0);
        rv[1] = 2'b01;
        tick();                                   // accept edge t
        rv[1] = 2'b00;
        ack[1] = 2'b01;                           // ack while result not yet valid
        tick();
        tick();
        ack[1] = 2'b00;
        tick();                                   // capture at t+3
        n_total++;
        if (rsv[1] !== 2'b01) begin n_bad++; $display("FAIL stray_early_ack: got rsv=%b want 01", rsv[1]); end
        ack[1] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_total++;
            if (rsv[1] !== 2'b01 || bsy[1] !== 1'b1) begin
                n_bad++; $display("FAIL stray_other_ack k%0d: got rsv=%b busy=%b want 01 1", k, rsv[1], bsy[1]);
            end
        end
        ack[1] = 2'b01;
        tick();
        n_total++;
        if (rsv[1] !== 2'b00) begin n_bad++; $display("FAIL stray_final_ack: got rsv=%b want 00", rsv[1]); end
        idle_inputs(1);
    endtask

    task automatic test_random(int d);
        logic [1:0] er;
        do_reset();
        for (int k = 0; k < 400; k++) begin
            rv[d] = 2'($urandom_range(0, 3));
            rand_ops(d, 0);
            rand_ops(d, 1);
            ack[d] = {($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0)};
            RESET = ($urandom_range(0, 49) == 0);
            #1;
            er = {exp_ready(d, 1), exp_ready(d, 0)};
            n_total++;
            if (rdy[d] !== er || bsy[d] !== (m_inf[d] && !RESET)) begin
                n_bad++; $display("FAIL rand_ready dut%0d cyc%0d: got rdy=%b busy=%b want rdy=%b busy=%b",
                                  d, k, rdy[d], bsy[d], er, (m_inf[d] && !RESET));
            end
            tick();
            n_total++;
            if (rsv[d] !== m_rv[d] || rF[d][0] !== m_F[d][0] || rF[d][1] !== m_F[d][1] ||
                rfl[d][0] !== m_fl[d][0] || rfl[d][1] !== m_fl[d][1]) begin
                n_bad++; $display("FAIL rand_resp dut%0d cyc%0d: got rsv=%b F0=%h F1=%h want rsv=%b F0=%h F1=%h",
                                  d, k, rsv[d], rF[d][0], rF[d][1], m_rv[d], m_F[d][0], m_F[d][1]);
            end
            n_total++;
            if (fuA[d] !== m_A[d] || fuB[d] !== m_B[d] || fuSH[d] !== m_SH[d] || fuFS[d] !== m_FS[d]) begin
                n_bad++; $display("FAIL rand_fu dut%0d cyc%0d: got A=%h B=%h want A=%h B=%h", d, k, fuA[d], fuB[d], m_A[d], m_B[d]);
            end
        end
        RESET = 1'b0;
        idle_inputs(d);
        do_reset();
    endtask

    initial begin
        idle_inputs(0);
        idle_inputs(1);
        test_reset();
        test_single();
        test_tie(0);
        test_tie(1);
        test_latency();
        test_backpressure();
        test_reset_exec();
        test_stray_ack();
        test_random(0);
        test_random(1);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/fu_arbiter.md
FU_ARBITER -- requirements
Module: fu_arbiter

Interface
REQ-001 Parameter FU_LAT, default 1, legal range 1..4: cycles from function-unit operand drive to result capture.
REQ-002 CLK  input  1  rising-edge clock for all state.
REQ-003 RESET  input  1  synchronous, active-high reset.
REQ-004 req0_valid, req1_valid  input  1 each  requester i has an operation pending.
REQ-005 req0_A, req0_B, req1_A, req1_B  input  32 each  operands A and B.
REQ-006 req0_SH, req1_SH  input  5 each  shift amount.
REQ-007 req0_FS, req1_FS  input  5 each  function select, passed to the function unit unchanged.
REQ-008 req0_ready, req1_ready  output  1 each  arbiter accepts requester i this cycle.
REQ-009 resp0_valid, resp1_valid  output  1 each  result available for requester i.
REQ-010 resp0_F, resp1_F  output  32 each  captured result.
REQ-011 resp0_flags, resp1_flags  output  4 each  captured {Z,C,N,V}.
REQ-012 resp0_ack, resp1_ack  input  1 each  requester i consumes its response.
REQ-013 fu_A, fu_B  output  32 each  operands to the function unit.
REQ-014 fu_SH, fu_FS  output  5 each  shift amount and function select to the function unit.
REQ-015 fu_F  input  32  function-unit result.
REQ-016 fu_Z, fu_C, fu_N, fu_V  input  1 each  function-unit flags.
REQ-017 busy  output  1  high whenever state is not IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; exactly one operation in flight at a time.
REQ-019 IDLE: if exactly one req_valid is high, that requester is granted; if both are high, the requester not granted last is granted (round-robin pointer last_grant).
REQ-020 reqi_ready is high only in IDLE, only for the granted requester, combinationally from the req_valid inputs and last_grant; it is never high for both requesters at once.
REQ-021 Accept = reqi_valid & reqi_ready at a rising edge: A, B, SH, FS are latched into operand registers, last_grant <= i, the latency counter is loaded with FU_LAT-1, and state goes to EXEC.
REQ-022 fu_A, fu_B, fu_SH, fu_FS are driven from the operand registers only, so they stay stable for the whole EXEC period regardless of requester inputs.
REQ-023 EXEC: the counter decrements each cycle; in the cycle where the counter is 0, fu_F and the flags are captured at that edge into the response registers of the granted requester, and state goes to RESP.
REQ-024 Latency: with an accept at edge t, capture occurs at edge t+FU_LAT and respi_valid is high from edge t+FU_LAT onward.
REQ-025 RESP: respi_valid for the granted requester stays high, with respi_F and respi_flags held constant, until respi_ack is sampled high; the other requester's resp_valid stays low.
REQ-026 At the edge where respi_ack is sampled high in RESP: respi_valid clears and state goes to IDLE; the next accept occurs no earlier than the following edge.
REQ-027 An ack arriving while resp_valid is low is ignored; an ack from the non-granted requester is ignored.
REQ-028 req_valid changes during EXEC or RESP have no effect on the operation in flight; arbitration happens only in IDLE.
REQ-029 The last captured respi_F and respi_flags values remain on the outputs after ack until they are overwritten by a new capture for that requester.

Reset
REQ-030 RESET sampled high sets state to IDLE and last_grant to 1, so requester 0 wins the first tie.
REQ-031 RESET sampled high clears the operand registers, so fu_A, fu_B, fu_SH, fu_FS = 0, and clears all resp_valid, resp_F and resp_flags to 0.
REQ-032 RESET during EXEC or RESP aborts the operation; no response is produced for it.
REQ-033 RESET has priority over accept, capture and ack occurring at the same edge.
REQ-034 busy and both ready outputs are low while RESET is high.

Verification
REQ-035 Single request, FU_LAT=1: req0 A=5, B=7, FS=00010 accepted at edge t; function-unit model returns F=12, flags 0000 -> resp0_valid high from edge t+1 with resp0_F=12; resp0_ack at edge t+3 -> idle, with req0_ready high again at t+4.
REQ-036 Tie after reset: both valid in the same cycle -> req0 is granted first; after its ack, req1 is granted next while req0 is still valid -> grant order alternates 0,1,0,1.
REQ-037 Latency, FU_LAT=3: accept at edge t -> capture exactly at edge t+3, with fu_A/fu_B stable over t..t+3 while req inputs toggle randomly.
REQ-038 Backpressure: ack withheld for 10 cycles -> resp_valid and data are held constant, req1 valid throughout is not accepted, and busy stays high.
REQ-039 Reset mid-EXEC: RESET at edge t+1 of an FU_LAT=3 operation -> no resp_valid is produced, all outputs are 0, and the first tie afterwards goes to req0.
REQ-040 Stray ack: resp1_ack pulsed while req0's result is pending, and during IDLE -> no state change and no resp_valid change.
